fb_pixel_codec: RTL and testbench
=================================

# fb_pixel_codec

Parametrised framebuffer codec between the VGA timing generator, the pixel-write FIFO and a single-port synchronous RAM. Packs PIX_BITS-wide pixels PIX_PER_WORD to a word, horizontally. During active video it streams upscaled pixels to the DAC path. During blanking it runs read-modify-write pixel updates and a whole-buffer clear.

## Interface
- FB_W, 160, framebuffer width in logical pixels; must be a multiple of PIX_PER_WORD.
- FB_H, 120, framebuffer height in logical pixels.
- PIX_BITS, 3, bits per pixel; bit order {R,G,B} for 3.
- PIX_PER_WORD, 8, pixels per RAM word; WORD_W = PIX_BITS*PIX_PER_WORD.
- SCALE, 4, integer upscale from logical pixels to screen pixels.
- X_W / Y_W, 10 / 10, widths of hpos/wr_x and vpos/wr_y.
- BORDER_PIX, 0, colour output for on-screen positions outside FB_W*SCALE x FB_H*SCALE.
- CLEAR_PIX, 0, colour written by clear.
- Derived: WPR = FB_W/PIX_PER_WORD; ADDR_W = clog2(FB_H*WPR).
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- hpos / vpos  in  X_W / Y_W  current screen position from the timing generator.
- display_on  in  1  active video; the read path owns the RAM while this is high.
- pix_out  out  PIX_BITS  display pixel.
- pix_valid  out  1  display_on delayed by 2 cycles.
- wr_valid / wr_ready  in / out  1 / 1  pixel-write handshake.
- wr_x / wr_y / wr_pix  in  X_W / Y_W / PIX_BITS  pixel write request.
- clear_req  in  1  pulse that starts a full clear.
- clear_busy  out  1  clear in progress.
- drop_cnt  out  16  saturating count of out-of-range writes dropped.
- mem_addr / mem_we / mem_wdata  out  ADDR_W / 1 / WORD_W  RAM port.
- mem_rdata  in  WORD_W  RAM data, valid 1 cycle after the address is sampled.

## Operation
- Word mapping: addr = y*WPR + x/PIX_PER_WORD. Slot s = x%PIX_PER_WORD occupies bits [s*PIX_BITS +: PIX_BITS].
- Read path (display_on=1):
  - Drive mem_addr = (vpos/SCALE)*WPR + (hpos/SCALE)/PIX_PER_WORD, with mem_we=0.
  - Delay the slot and the in-area flag two stages.
  - Register pix_out = in-area ? slot of mem_rdata : BORDER_PIX. Force pix_out = 0 when the delayed display_on is 0.
- Write FSM states: IDLE, RD, WR, HOLD, CLR.
  - IDLE: wr_ready = ~display_on & ~clear_busy. On handshake, latch x/y/pix.
    - If x>=FB_W or y>=FB_H, drop the request, increment drop_cnt (saturates at 0xFFFF) and stay in IDLE.
    - Otherwise go to RD.
  - RD: drive mem_addr = word address, then go to WR.
  - WR: mem_we=1, mem_wdata = mem_rdata with slot s replaced by pix and all other slots preserved, then go to IDLE.
  - display_on high while in RD or WR: suppress the write, go to HOLD and keep the latched request. HOLD goes to RD on the first cycle with display_on=0.
  - clear_req sampled in IDLE goes to CLR; clear_req sampled in RD/WR/HOLD is remembered and taken on the next entry to IDLE. In CLR, clear_busy=1: each cycle with display_on=0, write CLEAR_PIX replicated PIX_PER_WORD times to a counter address 0..FB_H*WPR-1. With display_on=1, pause with the counter held. After the last address, return to IDLE.
- Priority: a pending clear beats a new wr_valid. The read path always owns the RAM when display_on=1.
- Reset, including mid-operation: state IDLE; any latched request and pending clear are discarded. Registered outputs return to 0: pix_out, pix_valid, mem_we, mem_wdata, clear_busy, drop_cnt. wr_ready=0 and mem_addr=0 while reset is high.

## Timing
- Display latency: hpos/vpos to pix_out is 2 cycles; pix_valid tracks it.
- Uninterrupted pixel write takes 3 cycles (IDLE, RD, WR): peak 1 pixel per 3 clocks.
- mem_we is asserted only in WR and CLR, and never in a cycle with display_on=1.
- wr_ready is combinational from state and display_on; a transfer occurs only in cycles where wr_valid & wr_ready.
- Clear of the full buffer takes FB_H*WPR blanking cycles, plus 1 cycle to return to IDLE.

## Test plan
- Write (x=9, y=2, pix=3'b101) into a zeroed RAM -> single mem_we at addr 41 with wdata=24'h000028; all other slots unchanged.
- Back-to-back writes x=0 pix=7 then x=1 pix=2, y=0 -> addr 0 ends at 24'h000017 (RMW preserves slot 0).
- Display with hpos=36..39, vpos=8 after the first test -> pix_out=5 for 4 cycles, starting 2 cycles later. hpos=640 with display_on=1 -> BORDER_PIX.
- Write x=160 -> no mem_we, drop_cnt=1, wr_ready back to 1 next cycle.
- display_on rises in RD -> no write while active; in the first blanking cycle, RD then WR to the correct word with correct data.
- clear_req with CLEAR_PIX=3'b010 -> 2400 writes, addr 0..2399, wdata=24'h492492, clear_busy pauses during display_on; assert reset mid-clear -> mem_we=0 and clear_busy=0 next cycle.

Source files
------------

// File: rtl/fb_pixel_codec_if.sv
// Bundles for the framebuffer codec: pixel-write request channel
// and single-port RAM port.
interface fb_wr_if #(
  parameter int X_W      = 10,
  parameter int Y_W      = 10,
  parameter int PIX_BITS = 3
);
  logic                wr_valid;
  logic                wr_ready;
  logic [X_W-1:0]      wr_x;
  logic [Y_W-1:0]      wr_y;
  logic [PIX_BITS-1:0] wr_pix;

  modport master (
    output wr_valid, wr_x, wr_y, wr_pix,
    input  wr_ready
  );
  modport slave (
    input  wr_valid, wr_x, wr_y, wr_pix,
    output wr_ready
  );
endinterface

interface fb_mem_if #(
  parameter int ADDR_W = 12,
  parameter int WORD_W = 24
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;

  modport master (
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );
  modport slave (
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/fb_pixel_codec.sv
// Framebuffer codec: upscaled display read path plus blanking-time
// read-modify-write pixel updates and full-buffer clear.
module fb_pixel_codec #(
  parameter int FB_W         = 160,
  parameter int FB_H         = 120,
  parameter int PIX_BITS     = 3,
  parameter int PIX_PER_WORD = 8,
  parameter int SCALE        = 4,
  parameter int X_W          = 10,
  parameter int Y_W          = 10,
  parameter logic [PIX_BITS-1:0] BORDER_PIX = '0,
  parameter logic [PIX_BITS-1:0] CLEAR_PIX  = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [X_W-1:0]      hpos,
  input  logic [Y_W-1:0]      vpos,
  input  logic                display_on,
  output logic [PIX_BITS-1:0] pix_out,
  output logic                pix_valid,
  fb_wr_if.slave              wr,
  input  logic                clear_req,
  output logic                clear_busy,
  output logic [15:0]         drop_cnt,
  fb_mem_if.master            mem
);

  localparam int WORD_W = PIX_BITS * PIX_PER_WORD;
  localparam int WPR    = FB_W / PIX_PER_WORD;
  localparam int WORDS  = FB_H * WPR;
  localparam int ADDR_W = $clog2(WORDS);
  localparam int SLOT_W =
    (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(WORDS - 1);
  localparam logic [WORD_W-1:0] CLEAR_WORD =
    {PIX_PER_WORD{CLEAR_PIX}};

  typedef enum logic [2:0] {
    IDLE, RD, WR, HOLD, CLR
  } state_t;

  function automatic logic [ADDR_W-1:0] word_addr(
    input logic [X_W-1:0] x,
    input logic [Y_W-1:0] y
  );
    logic [31:0] a;
    a = 32'(y) * 32'(WPR) + 32'(x) / 32'(PIX_PER_WORD);
    return a[ADDR_W-1:0];
  endfunction

  function automatic logic [SLOT_W-1:0] slot_of(
    input logic [X_W-1:0] x
  );
    logic [31:0] s;
    s = 32'(x) % 32'(PIX_PER_WORD);
    return s[SLOT_W-1:0];
  endfunction

  // Display read path
  logic [X_W-1:0]    sx;
  logic [Y_W-1:0]    sy;
  logic              in_area;
  logic [ADDR_W-1:0] rd_addr;
  logic              d1_on;
  logic              d1_area;
  logic [SLOT_W-1:0] d1_slot;

  assign sx      = X_W'(32'(hpos) / 32'(SCALE));
  assign sy      = Y_W'(32'(vpos) / 32'(SCALE));
  assign in_area = (32'(sx) < 32'(FB_W)) &&
                   (32'(sy) < 32'(FB_H));
  assign rd_addr = word_addr(sx, sy);

  always_ff @(posedge clk) begin
    if (reset) begin
      d1_on     <= 1'b0;
      d1_area   <= 1'b0;
      d1_slot   <= '0;
      pix_out   <= '0;
      pix_valid <= 1'b0;
    end else begin
      d1_on     <= display_on;
      d1_area   <= in_area;
      d1_slot   <= slot_of(sx);
      pix_valid <= d1_on;
      if (!d1_on)
        pix_out <= '0;
      else if (d1_area)
        pix_out <= mem.mem_rdata[d1_slot*PIX_BITS +: PIX_BITS];
      else
        pix_out <= BORDER_PIX;
    end
  end

  // Write / clear FSM
  state_t            state;
  state_t            state_n;
  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic [PIX_BITS-1:0] r_pix;
  logic              clr_pend;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic [SLOT_W-1:0] r_slot;
  logic              fire;
  logic              in_range;
  logic [ADDR_W-1:0] fsm_addr;
  logic              fsm_we;
  logic [WORD_W-1:0] fsm_wdata;

  assign wr_addr  = word_addr(r_x, r_y);
  assign r_slot   = slot_of(r_x);
  assign in_range = (32'(wr.wr_x) < 32'(FB_W)) &&
                    (32'(wr.wr_y) < 32'(FB_H));
  // A clear, pending or just requested, outranks a new write
  assign wr.wr_ready = (state == IDLE) & ~display_on &
                       ~clr_pend & ~clear_req & ~reset;
  assign fire = wr.wr_valid & wr.wr_ready;

  always_comb begin
    state_n   = state;
    fsm_addr  = '0;
    fsm_we    = 1'b0;
    fsm_wdata = '0;
    unique case (state)
      IDLE: begin
        if (clr_pend || clear_req)
          state_n = CLR;
        else if (fire && in_range)
          state_n = RD;
      end
      RD: begin
        fsm_addr = wr_addr;
        state_n  = display_on ? HOLD : WR;
      end
      WR: begin
        fsm_addr = wr_addr;
        if (display_on) begin
          state_n = HOLD;
        end else begin
          fsm_we    = 1'b1;
          fsm_wdata = mem.mem_rdata;
          fsm_wdata[r_slot*PIX_BITS +: PIX_BITS] = r_pix;
          state_n   = IDLE;
        end
      end
      HOLD: begin
        if (!display_on)
          state_n = RD;
      end
      CLR: begin
        fsm_addr = clr_cnt;
        if (!display_on) begin
          fsm_we    = 1'b1;
          fsm_wdata = CLEAR_WORD;
          if (clr_cnt == LAST)
            state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      r_x      <= '0;
      r_y      <= '0;
      r_pix    <= '0;
      clr_pend <= 1'b0;
      clr_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_n;
      if (fire) begin
        r_x   <= wr.wr_x;
        r_y   <= wr.wr_y;
        r_pix <= wr.wr_pix;
        if (!in_range && drop_cnt != 16'hFFFF)
          drop_cnt <= drop_cnt + 16'd1;
      end
      if (clear_req && (state == RD || state == WR ||
                        state == HOLD))
        clr_pend <= 1'b1;
      else if (state == IDLE && state_n == CLR)
        clr_pend <= 1'b0;
      if (state != CLR)
        clr_cnt <= '0;
      else if (!display_on)
        clr_cnt <= clr_cnt + 1'b1;
    end
  end

  assign mem.mem_addr  = reset ? '0 :
                         (display_on ? rd_addr : fsm_addr);
  assign mem.mem_we    = fsm_we & ~reset;
  assign mem.mem_wdata = reset ? '0 : fsm_wdata;
  assign clear_busy    = (state == CLR) & ~reset;

endmodule

// File: tb/tb_fb_pixel_codec.sv
// Directed bench for fb_pixel_codec with a behavioural
// single-port RAM (read-first, 1-cycle read latency).
module tb_fb_pixel_codec;

  localparam int WORDS = 2400;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hpos;
  logic [9:0]  vpos;
  logic        display_on;
  logic [2:0]  pix_out;
  logic        pix_valid;
  logic        clear_req;
  logic        clear_busy;
  logic [15:0] drop_cnt;

  fb_wr_if  #(.X_W(10), .Y_W(10), .PIX_BITS(3)) wr ();
  fb_mem_if #(.ADDR_W(12), .WORD_W(24))         mem ();

  fb_pixel_codec #(.CLEAR_PIX(3'b010)) dut (
    .clk        (clk),
    .reset      (reset),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .pix_out    (pix_out),
    .pix_valid  (pix_valid),
    .wr         (wr),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .drop_cnt   (drop_cnt),
    .mem        (mem)
  );

  always #5 clk = ~clk;

  bit [23:0] ram [WORDS];

  always @(posedge clk) begin
    if (mem.mem_we)
      ram[mem.mem_addr] <= mem.mem_wdata;
    mem.mem_rdata <= ram[mem.mem_addr];
  end

  int we_cnt = 0;
  int viol = 0;
  int clr_writes = 0;
  int clr_err = 0;
  logic [11:0] clr_exp = '0;

  always @(posedge clk) begin
    if (mem.mem_we) we_cnt <= we_cnt + 1;
    if (mem.mem_we && display_on) viol <= viol + 1;
    if (!clear_busy) begin
      clr_exp <= '0;
    end else if (mem.mem_we) begin
      if (mem.mem_addr != clr_exp ||
          mem.mem_wdata != 24'h492492)
        clr_err <= clr_err + 1;
      clr_exp    <= clr_exp + 12'd1;
      clr_writes <= clr_writes + 1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [9:0] x,
                      input logic [9:0] y,
                      input logic [2:0] p);
    int n;
    n = 0;
    wr.wr_valid = 1'b1;
    wr.wr_x     = x;
    wr.wr_y     = y;
    wr.wr_pix   = p;
    #1;
    while (!wr.wr_ready && n < 20) begin
      tick();
      #1;
      n++;
    end
    check("hs_wait", 32'(n < 20), 32'd1);
    @(posedge clk);
    #1;
    wr.wr_valid = 1'b0;
  endtask

  logic [9:0] hv [7] = '{10'd36, 10'd37, 10'd38, 10'd39,
                         10'd640, 10'd0, 10'd4};
  logic [9:0] vv [7] = '{10'd8, 10'd8, 10'd8, 10'd8,
                         10'd8, 10'd0, 10'd0};
  logic [2:0] ep [10] = '{3'd0, 3'd0, 3'd5, 3'd5, 3'd5,
                          3'd5, 3'd0, 3'd7, 3'd2, 3'd0};
  logic       ev [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                          1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int n;
    reset       = 1'b1;
    hpos        = '0;
    vpos        = '0;
    display_on  = 1'b0;
    clear_req   = 1'b0;
    wr.wr_valid = 1'b0;
    wr.wr_x     = '0;
    wr.wr_y     = '0;
    wr.wr_pix   = '0;
    repeat (3) tick();
    check("rst_ready", 32'(wr.wr_ready), 32'd0);
    check("rst_addr",  32'(mem.mem_addr), 32'd0);
    check("rst_we",    32'(mem.mem_we), 32'd0);
    check("rst_pix",   32'(pix_out), 32'd0);
    check("rst_pv",    32'(pix_valid), 32'd0);
    check("rst_busy",  32'(clear_busy), 32'd0);
    check("rst_drop",  32'(drop_cnt), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_ready", 32'(wr.wr_ready), 32'd1);

    // single RMW write, cycle by cycle
    send(10'd9, 10'd2, 3'd5);
    check("rd_we",    32'(mem.mem_we), 32'd0);
    check("rd_addr",  32'(mem.mem_addr), 32'd41);
    tick();
    check("wr_we",    32'(mem.mem_we), 32'd1);
    check("wr_addr",  32'(mem.mem_addr), 32'd41);
    check("wr_data",  32'(mem.mem_wdata), 32'h28);
    tick();
    check("wr_ready", 32'(wr.wr_ready), 32'd1);
    check("ram41",    32'(ram[41]), 32'h28);
    check("ram40",    32'(ram[40]), 32'h0);
    check("ram42",    32'(ram[42]), 32'h0);

    // back-to-back writes into one word
    send(10'd0, 10'd0, 3'd7);
    send(10'd1, 10'd0, 3'd2);
    repeat (3) tick();
    check("ram0", 32'(ram[0]), 32'h17);

    // display stream, 2-cycle latency
    for (int c = 0; c < 10; c++) begin
      if (c < 7) begin
        display_on = 1'b1;
        hpos = hv[c];
        vpos = vv[c];
      end else begin
        display_on = 1'b0;
      end
      #1;
      if (c == 0) begin
        check("disp_addr",  32'(mem.mem_addr), 32'd41);
        check("disp_ready", 32'(wr.wr_ready), 32'd0);
      end
      check($sformatf("pix%0d", c), 32'(pix_out), 32'(ep[c]));
      check($sformatf("pv%0d", c), 32'(pix_valid), 32'(ev[c]));
      tick();
    end

    // out-of-range write dropped
    w0 = we_cnt;
    send(10'd160, 10'd0, 3'd1);
    check("drop_we",    32'(mem.mem_we), 32'd0);
    check("drop_cnt",   32'(drop_cnt), 32'd1);
    check("drop_ready", 32'(wr.wr_ready), 32'd1);
    repeat (2) tick();
    check("drop_nowr",  32'(we_cnt - w0), 32'd0);

    // display_on rises while in RD
    w0 = we_cnt;
    send(10'd20, 10'd3, 3'd6);
    display_on = 1'b1;
    hpos = '0;
    vpos = '0;
    #1;
    check("hold_we", 32'(mem.mem_we), 32'd0);
    repeat (3) tick();
    display_on = 1'b0;
    repeat (5) tick();
    check("hold_ram62", 32'(ram[62]), 32'h6000);
    check("hold_wcnt",  32'(we_cnt - w0), 32'd1);
    check("hold_viol",  32'(viol), 32'd0);

    // full clear with a display pause
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("clr_busy",  32'(clear_busy), 32'd1);
    check("clr_ready", 32'(wr.wr_ready), 32'd0);
    repeat (100) tick();
    display_on = 1'b1;
    repeat (5) tick();
    check("clr_pause", 32'(clear_busy), 32'd1);
    display_on = 1'b0;
    n = 0;
    while (clear_busy && n < 3000) begin
      tick();
      n++;
    end
    check("clr_done",   32'(n < 3000), 32'd1);
    check("clr_writes", 32'(clr_writes), 32'd2400);
    check("clr_err",    32'(clr_err), 32'd0);
    check("clr_ram0",   32'(ram[0]), 32'h492492);
    check("clr_ram41",  32'(ram[41]), 32'h492492);
    check("clr_ram_end", 32'(ram[2399]), 32'h492492);
    check("clr_viol",   32'(viol), 32'd0);

    // clear requested during a write, then reset mid-clear
    send(10'd5, 10'd5, 3'd1);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("pend_wr_we", 32'(mem.mem_we), 32'd1);
    tick();
    check("pend_ready", 32'(wr.wr_ready), 32'd0);
    check("pend_ram100", 32'(ram[100]), 32'h48A492);
    tick();
    check("pend_busy", 32'(clear_busy), 32'd1);
    repeat (50) tick();
    reset = 1'b1;
    tick();
    check("mrst_we",   32'(mem.mem_we), 32'd0);
    check("mrst_busy", 32'(clear_busy), 32'd0);
    check("mrst_addr", 32'(mem.mem_addr), 32'd0);
    check("mrst_drop", 32'(drop_cnt), 32'd0);
    reset = 1'b0;
    tick();
    check("post_busy",  32'(clear_busy), 32'd0);
    check("post_ready", 32'(wr.wr_ready), 32'd1);
    tick();
    check("post_busy2", 32'(clear_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
